// File: rtl/br_result_queue_pkg.sv
// Shared types for the branch-result queue that sits between integer
// write-back and the BTB / branch-predictor update port.
//   - brq_state_e : queue control state (INIT while predictor tables clear)
//   - br_flags_t  : per-entry direction / kind / misprediction flags
//   - br_entry_t  : one resolved-branch record at the default PC width
//   - brq_sat_add16 : saturating 16-bit add for the drop counter
package br_result_queue_pkg;

    localparam int unsigned BR_PC_WIDTH    = 32;
    localparam int unsigned DROP_CNT_WIDTH = 16;

    typedef enum logic {
        BRQ_INIT = 1'b0,
        BRQ_RUN  = 1'b1
    } brq_state_e;

    typedef struct packed {
        logic taken;
        logic cond_br;
        logic mispred;
    } br_flags_t;

    typedef struct packed {
        logic [BR_PC_WIDTH-1:0] pc;
        logic [BR_PC_WIDTH-1:0] target;
        br_flags_t              flags;
    } br_entry_t;

    // Saturating add; the drop counter sticks at all-ones.
    function automatic logic [DROP_CNT_WIDTH-1:0] brq_sat_add16(
        input logic [DROP_CNT_WIDTH-1:0] a,
        input logic [DROP_CNT_WIDTH-1:0] b
    );
        logic [DROP_CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DROP_CNT_WIDTH] ? '1 : sum[DROP_CNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/br_result_lane_compactor.sv
// Lane compactor for the branch-result queue.
// Gives each valid lane its slot offset from the queue tail (prefix count of
// valid lanes below it) and decides which lanes fit into the free capacity.
// Lower lane indices win, so overflow always drops the highest lanes first.
// Ports:
//   valid_i      : per-lane valid
//   cap_i        : free slots available this cycle
//   accept_c_o   : lane is written this cycle
//   offset_c_o   : per-lane offset from tail, lane i at [i*CNT_W +: CNT_W]
//   enq_cnt_c_o  : number of lanes accepted
//   drop_cnt_c_o : number of valid lanes rejected for lack of space
module br_result_lane_compactor #(
    parameter int unsigned LANES = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic [LANES-1:0]       valid_i,
    input  logic [CNT_W-1:0]       cap_i,
    output logic [LANES-1:0]       accept_c_o,
    output logic [LANES*CNT_W-1:0] offset_c_o,
    output logic [CNT_W-1:0]       enq_cnt_c_o,
    output logic [CNT_W-1:0]       drop_cnt_c_o
);

    // Running prefix count; accepted lanes are always a prefix of the valid
    // lanes, so the valid prefix count is also the compacted slot offset.
    always_comb begin
        logic [CNT_W-1:0] run;
        run          = '0;
        accept_c_o   = '0;
        offset_c_o   = '0;
        drop_cnt_c_o = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            offset_c_o[i*CNT_W +: CNT_W] = run;
            if (valid_i[i]) begin
                if (run < cap_i) begin
                    accept_c_o[i] = 1'b1;
                    run           = run + CNT_W'(1);
                end else begin
                    drop_cnt_c_o = drop_cnt_c_o + CNT_W'(1);
                end
            end
        end
        enq_cnt_c_o = run;
    end

endmodule

// File: rtl/br_result_queue.sv
// Branch-result queue: collects executed branches from the integer
// write-back lanes and presents them one per cycle to the BTB / branch
// predictor update port. Sole producer of predictor-update results.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rstStart        : predictor tables initialising; nothing is delivered
//   inValid/inPC/inTarget/inTaken/inCondBr/inMispred : per-lane results
//   updReady        : consumer accepts the head entry this cycle
//   updValid/updPC/updTarget/updTaken/updCondBr/updMispred : head entry
//   almostFull      : stall request toward integer issue
//   dropCount       : saturating count of results lost to a full queue
module br_result_queue
    import br_result_queue_pkg::*;
#(
    parameter int unsigned INT_ISSUE_WIDTH = 2,
    parameter int unsigned QUEUE_DEPTH     = 8,
    parameter int unsigned PC_WIDTH        = BR_PC_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rstStart,
    input  logic [INT_ISSUE_WIDTH-1:0]        inValid,
    input  logic [INT_ISSUE_WIDTH*PC_WIDTH-1:0] inPC,
    input  logic [INT_ISSUE_WIDTH*PC_WIDTH-1:0] inTarget,
    input  logic [INT_ISSUE_WIDTH-1:0]        inTaken,
    input  logic [INT_ISSUE_WIDTH-1:0]        inCondBr,
    input  logic [INT_ISSUE_WIDTH-1:0]        inMispred,
    input  logic                              updReady,
    output logic                              updValid,
    output logic [PC_WIDTH-1:0]               updPC,
    output logic [PC_WIDTH-1:0]               updTarget,
    output logic                              updTaken,
    output logic                              updCondBr,
    output logic                              updMispred,
    output logic                              almostFull,
    output logic [DROP_CNT_WIDTH-1:0]         dropCount
);

    localparam int unsigned PTR_W       = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W       = PTR_W + 1;
    localparam int unsigned AFULL_LEVEL = QUEUE_DEPTH - INT_ISSUE_WIDTH;

    brq_state_e                state_q, state_d;
    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

    // Payload storage; never reset, only read when count is non-zero.
    logic [PC_WIDTH-1:0] pc_mem_q  [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0] tgt_mem_q [QUEUE_DEPTH];
    br_flags_t           flg_mem_q [QUEUE_DEPTH];

    logic                             flush_c;
    logic                             upd_valid_c;
    logic                             deq_c;
    logic [CNT_W-1:0]                 cap_c;
    logic [INT_ISSUE_WIDTH-1:0]       accept_c;
    logic [INT_ISSUE_WIDTH*CNT_W-1:0] offset_c;
    logic [CNT_W-1:0]                 enq_cnt_c;
    logic [CNT_W-1:0]                 drop_cnt_c;
    logic [PTR_W-1:0]                 slot_c [INT_ISSUE_WIDTH];
    br_flags_t                        head_flags_c;

    // Re-entering predictor init from RUN throws away everything queued.
    assign flush_c = (state_q == BRQ_RUN) && rstStart;

    // Nothing is offered while tables are being initialised, even in the
    // cycle rstStart rises before the state register has left RUN.
    assign upd_valid_c = (state_q == BRQ_RUN) && (count_q != '0) && !rstStart;
    assign deq_c       = upd_valid_c && updReady;

    // Capacity is based on the start-of-cycle count; a slot freed by this
    // cycle's dequeue is not available until the next cycle.
    assign cap_c = CNT_W'(QUEUE_DEPTH) - count_q;

    br_result_lane_compactor #(
        .LANES (INT_ISSUE_WIDTH),
        .CNT_W (CNT_W)
    ) u_compactor (
        .valid_i      (inValid),
        .cap_i        (cap_c),
        .accept_c_o   (accept_c),
        .offset_c_o   (offset_c),
        .enq_cnt_c_o  (enq_cnt_c),
        .drop_cnt_c_o (drop_cnt_c)
    );

    // Physical slot per lane; pointer width makes the wrap implicit.
    always_comb begin
        for (int unsigned i = 0; i < INT_ISSUE_WIDTH; i++) begin
            slot_c[i] = tail_q + PTR_W'(offset_c[i*CNT_W +: CNT_W]);
        end
    end

    // Next-state for control state, pointers, count and drop counter.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = drop_q;

        unique case (state_q)
            BRQ_INIT: if (!rstStart) state_d = BRQ_RUN;
            BRQ_RUN:  if (rstStart)  state_d = BRQ_INIT;
            default:  state_d = BRQ_INIT;
        endcase

        if (flush_c) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_c);
            tail_d  = tail_q + PTR_W'(enq_cnt_c);
            count_d = count_q + enq_cnt_c - CNT_W'(deq_c);
            drop_d  = brq_sat_add16(drop_q, DROP_CNT_WIDTH'(drop_cnt_c));
        end
    end

    // Control registers; reset overrides all same-cycle activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BRQ_INIT;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Payload write for every accepted lane into its compacted slot.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < INT_ISSUE_WIDTH; i++) begin
            if (!rst && !flush_c && accept_c[i]) begin
                pc_mem_q[slot_c[i]]  <= inPC[i*PC_WIDTH +: PC_WIDTH];
                tgt_mem_q[slot_c[i]] <= inTarget[i*PC_WIDTH +: PC_WIDTH];
                flg_mem_q[slot_c[i]] <= '{taken:   inTaken[i],
                                          cond_br: inCondBr[i],
                                          mispred: inMispred[i]};
            end
        end
    end

    // Head entry is read straight from storage: zero-cycle read latency.
    assign head_flags_c = flg_mem_q[head_q];
    assign updValid     = upd_valid_c;
    assign updPC        = pc_mem_q[head_q];
    assign updTarget    = tgt_mem_q[head_q];
    assign updTaken     = head_flags_c.taken;
    assign updCondBr    = head_flags_c.cond_br;
    assign updMispred   = head_flags_c.mispred;
    assign almostFull   = (count_q >= CNT_W'(AFULL_LEVEL));
    assign dropCount    = drop_q;

endmodule

// File: tb/tb_br_result_queue.sv
// Directed scoreboard bench for br_result_queue (2 lanes, depth 8, 32-bit PC).
module tb_br_result_queue;

    localparam int unsigned W     = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PCW   = 32;

    logic           clk;
    logic           rst;
    logic           rstStart;
    logic [W-1:0]   inValid;
    logic [W*PCW-1:0] inPC;
    logic [W*PCW-1:0] inTarget;
    logic [W-1:0]   inTaken;
    logic [W-1:0]   inCondBr;
    logic [W-1:0]   inMispred;
    logic           updReady;
    logic           updValid;
    logic [PCW-1:0] updPC;
    logic [PCW-1:0] updTarget;
    logic           updTaken;
    logic           updCondBr;
    logic           updMispred;
    logic           almostFull;
    logic [15:0]    dropCount;

    br_result_queue #(
        .INT_ISSUE_WIDTH (W),
        .QUEUE_DEPTH     (DEPTH),
        .PC_WIDTH        (PCW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rstStart   (rstStart),
        .inValid    (inValid),
        .inPC       (inPC),
        .inTarget   (inTarget),
        .inTaken    (inTaken),
        .inCondBr   (inCondBr),
        .inMispred  (inMispred),
        .updReady   (updReady),
        .updValid   (updValid),
        .updPC      (updPC),
        .updTarget  (updTarget),
        .updTaken   (updTaken),
        .updCondBr  (updCondBr),
        .updMispred (updMispred),
        .almostFull (almostFull),
        .dropCount  (dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [2:0]  fl;   // {taken, condBr, mispred}
    } exp_t;

    exp_t        sb[$];
    bit          m_run;
    int          m_drop;
    int          checks;
    int          errors;
    logic [31:0] pc_seq;

    function automatic logic [31:0] tgt_of(input logic [31:0] p);
        return p ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [2:0] flags_of(input logic [31:0] p);
        return {p[8], p[9], p[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check before posedge, update model.
    task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                        input logic rdy, input logic rs);
        bit   exp_v;
        int   n0;
        int   cap;
        int   acc;
        exp_t e;
        logic [31:0] pl;
        inValid   = v;
        inPC      = {p1, p0};
        inTarget  = {tgt_of(p1), tgt_of(p0)};
        inTaken   = {p1[8],  p0[8]};
        inCondBr  = {p1[9],  p0[9]};
        inMispred = {p1[10], p0[10]};
        updReady  = rdy;
        rstStart  = rs;
        #1;
        exp_v = m_run && (sb.size() != 0) && !rs;
        chk("updValid",   32'(updValid),   32'(exp_v));
        chk("almostFull", 32'(almostFull), 32'(sb.size() >= int'(DEPTH - W)));
        chk("dropCount",  32'(dropCount),  32'(m_drop));
        if (exp_v) begin
            e = sb[0];
            chk("updPC",     updPC,     e.pc);
            chk("updTarget", updTarget, e.tgt);
            chk("updFlags",  32'({updTaken, updCondBr, updMispred}), 32'(e.fl));
        end
        @(posedge clk);
        if (rs && m_run) begin
            sb.delete();
            m_run = 1'b0;
        end else begin
            n0  = sb.size();
            cap = int'(DEPTH) - n0;
            acc = 0;
            if (exp_v && rdy) void'(sb.pop_front());
            for (int i = 0; i < int'(W); i++) begin
                if (v[i]) begin
                    pl = (i == 0) ? p0 : p1;
                    if (acc < cap) begin
                        sb.push_back('{pc: pl, tgt: tgt_of(pl), fl: flags_of(pl)});
                        acc++;
                    end else begin
                        m_drop = (m_drop + 1 > 65535) ? 65535 : m_drop + 1;
                    end
                end
            end
            if (!m_run && !rs) m_run = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic step_a(input logic [1:0] v, input logic rdy, input logic rs);
        step(v, pc_seq, pc_seq + 32'h104, rdy, rs);
        pc_seq = pc_seq + 32'h230;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            step_a(2'b00, 1'b1, 1'b0);
            n++;
        end
    endtask

    initial begin
        int guard;
        checks = 0;
        errors = 0;
        m_run  = 1'b0;
        m_drop = 0;
        pc_seq = 32'h0000_1000;

        // Reset with queue activity present: reset must win.
        rst = 1'b1; rstStart = 1'b1; inValid = 2'b11; updReady = 1'b1;
        inPC = {32'h2000, 32'h1000}; inTarget = '0;
        inTaken = '0; inCondBr = '0; inMispred = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_updValid",   32'(updValid),   32'd0);
        chk("rst_almostFull", 32'(almostFull), 32'd0);
        chk("rst_dropCount",  32'(dropCount),  32'd0);
        rst = 1'b0;

        // INIT -> RUN, queue still empty.
        step_a(2'b00, 1'b1, 1'b0);
        step_a(2'b00, 1'b1, 1'b0);

        // Two lanes in one cycle, delivered in lane order.
        step(2'b11, 32'h100, 32'h200, 1'b1, 1'b0);
        step_a(2'b00, 1'b1, 1'b0);
        step_a(2'b00, 1'b1, 1'b0);
        step_a(2'b00, 1'b1, 1'b0);

        // Fill to 8 with consumer stalled, then overflow both lanes.
        repeat (4) step_a(2'b11, 1'b0, 1'b0);
        step_a(2'b11, 1'b0, 1'b0);
        // Count 8 -> 7 by one dequeue.
        step_a(2'b00, 1'b1, 1'b0);
        // Count 7: one slot, lane1 dropped, simultaneous dequeue keeps 7.
        step_a(2'b11, 1'b1, 1'b0);
        drain();
        // Empty queue with updReady high: no dequeue.
        step_a(2'b00, 1'b1, 1'b0);

        // Advance tail to slot 6, then enqueue 4 across wrap.
        step_a(2'b11, 1'b0, 1'b0);
        step_a(2'b01, 1'b0, 1'b0);
        drain();
        step_a(2'b01, 1'b0, 1'b0);
        step_a(2'b10, 1'b0, 1'b0);
        step_a(2'b11, 1'b0, 1'b0);
        drain();

        // Head held stable under back-pressure while new entries arrive.
        step_a(2'b01, 1'b0, 1'b0);
        repeat (5) step_a(2'b01, 1'b0, 1'b0);
        drain();

        // Flush from RUN with 3 entries; same-cycle inputs are not drops.
        step_a(2'b11, 1'b0, 1'b0);
        step_a(2'b01, 1'b0, 1'b0);
        step_a(2'b11, 1'b1, 1'b1);
        step_a(2'b00, 1'b1, 1'b0);
        step_a(2'b00, 1'b1, 1'b0);
        step_a(2'b11, 1'b1, 1'b0);
        drain();

        // INIT still accepts enqueues but does not present them.
        step_a(2'b11, 1'b0, 1'b0);
        step_a(2'b01, 1'b1, 1'b1);
        step_a(2'b10, 1'b1, 1'b1);
        step_a(2'b00, 1'b1, 1'b0);
        drain();

        // Drop counter saturation.
        repeat (4) step_a(2'b11, 1'b0, 1'b0);
        guard = 0;
        while (m_drop < 65535 && guard < 40000) begin
            step_a(2'b11, 1'b0, 1'b0);
            guard++;
        end
        repeat (2) step_a(2'b11, 1'b0, 1'b0);
        chk("drop_saturated", 32'(dropCount), 32'hFFFF);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
